// File: rtl/snake_draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_draw_engine
// Brief    : HPS command FIFO feeding a block/clear pixel writer into the VGA
//            pixel buffer, with game-state and score registers.
// Revision : 1.0 - initial release
// ============================================================================
module snake_draw_engine #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CELL_LOG2    = 2,
  parameter int unsigned SCREEN_W     = 320,
  parameter int unsigned SCREEN_H     = 240,
  parameter logic [31:0] PX_BASE      = 32'h0800_0000,
  parameter logic [15:0] SNAKE_COLOUR = 16'hFF00,
  parameter logic [15:0] BG_COLOUR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  hps_address,
  input  logic        hps_read,
  output logic [31:0] hps_readdata,
  input  logic        hps_write,
  input  logic [31:0] hps_writedata,
  output logic        hps_waitrequest,
  output logic [31:0] vga_px_address,
  output logic        vga_px_write,
  output logic [15:0] vga_px_writedata,
  input  logic        vga_px_waitrequest
);

  localparam int unsigned c_aw = $clog2(FIFO_DEPTH);
  localparam int unsigned c_xw = 9 + CELL_LOG2;
  localparam int unsigned c_yw = 8 + CELL_LOG2;
  localparam logic [c_xw-1:0]      c_w_lim    = c_xw'(SCREEN_W);
  localparam logic [c_yw-1:0]      c_h_lim    = c_yw'(SCREEN_H);
  localparam logic [8:0]           c_clr_xmax = 9'(SCREEN_W - 1);
  localparam logic [7:0]           c_clr_ymax = 8'(SCREEN_H - 1);
  localparam logic [CELL_LOG2-1:0] c_dmax     = '1;
  localparam logic [CELL_LOG2-1:0] c_one_d    = CELL_LOG2'(1);
  localparam logic [13:0] c_cmd_start = 14'd0;
  localparam logic [13:0] c_cmd_end   = 14'd1;
  localparam logic [13:0] c_cmd_add   = 14'd2;
  localparam logic [13:0] c_cmd_del   = 14'd3;
  localparam logic [13:0] c_cmd_score = 14'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DRAW   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  // Command FIFO
  logic [31:0]     fifo_mem_q [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_aw:0]   count_q;
  logic            fifo_full, fifo_empty, push, pop;

  state_t                state_q, state_d;
  logic [31:0]           cmd_q, cmd_d;
  logic [CELL_LOG2-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic [8:0]            cx_q, cx_d;
  logic [7:0]            cy_q, cy_d;
  logic                  playing_q, playing_d;
  logic                  snake_col_q, snake_col_d;
  logic [15:0]           score_q, score_d;
  logic                  busy;
  logic [c_xw-1:0]       draw_px;
  logic [c_yw-1:0]       draw_py;
  logic                  draw_in_range;

  assign fifo_full  = (count_q == (c_aw+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a write against a full FIFO still lands.
  assign push            = hps_write && (hps_address == 4'd0) && (!fifo_full || pop);
  assign hps_waitrequest = hps_write && (hps_address == 4'd0) && fifo_full && !pop;
  assign busy            = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= hps_writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (c_aw+1)'(1);
        2'b01:   count_q <= count_q - (c_aw+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Block origin is cell<<CELL_LOG2 and dx < CELL, so concatenation is the exact sum.
  assign draw_px       = {cmd_q[9:1], dx_q};
  assign draw_py       = {cmd_q[17:10], dy_q};
  assign draw_in_range = (draw_px < c_w_lim) && (draw_py < c_h_lim);

  always_comb begin
    vga_px_write     = 1'b0;
    vga_px_address   = PX_BASE;
    vga_px_writedata = '0;
    if (state_q == ST_DRAW && draw_in_range) begin
      vga_px_write     = 1'b1;
      vga_px_address   = PX_BASE | {14'b0, draw_py[7:0], draw_px[8:0], 1'b0};
      vga_px_writedata = snake_col_q ? SNAKE_COLOUR : BG_COLOUR;
    end else if (state_q == ST_CLEAR) begin
      vga_px_write     = 1'b1;
      vga_px_address   = PX_BASE | {14'b0, cy_q, cx_q, 1'b0};
      vga_px_writedata = BG_COLOUR;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    playing_d   = playing_q;
    snake_col_d = snake_col_q;
    score_d     = score_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cmd_d   = fifo_mem_q[rd_ptr_q];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        case (cmd_q[31:18])
          c_cmd_start: begin
            playing_d = 1'b1;
            cx_d      = '0;
            cy_d      = '0;
            state_d   = ST_CLEAR;
          end
          c_cmd_end:   playing_d = 1'b0;
          c_cmd_add, c_cmd_del: begin
            if (playing_q) begin
              dx_d        = '0;
              dy_d        = '0;
              snake_col_d = (cmd_q[31:18] == c_cmd_add);
              state_d     = ST_DRAW;
            end
          end
          c_cmd_score: score_d = cmd_q[15:0];
          default: ;
        endcase
      end
      ST_DRAW: begin
        // Off-screen pixels are stepped over without a bus strobe.
        if (!draw_in_range || !vga_px_waitrequest) begin
          if (dx_q == c_dmax) begin
            dx_d = '0;
            if (dy_q == c_dmax) state_d = ST_IDLE;
            else                dy_d    = dy_q + c_one_d;
          end else begin
            dx_d = dx_q + c_one_d;
          end
        end
      end
      ST_CLEAR: begin
        if (!vga_px_waitrequest) begin
          if (cx_q == c_clr_xmax) begin
            cx_d = '0;
            if (cy_q == c_clr_ymax) state_d = ST_IDLE;
            else                    cy_d    = cy_q + 8'd1;
          end else begin
            cx_d = cx_q + 9'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      playing_q   <= 1'b0;
      snake_col_q <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      playing_q   <= playing_d;
      snake_col_q <= snake_col_d;
      score_q     <= score_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hps_readdata <= '0;
    end else if (hps_read) begin
      case (hps_address)
        4'd0:    hps_readdata <= {16'b0, 8'(count_q), 5'b0, fifo_full, busy, playing_q};
        4'd1:    hps_readdata <= {16'b0, score_q};
        default: hps_readdata <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_draw_engine
// Brief    : Directed vector bench for snake_draw_engine on an 18x10 screen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_draw_engine;

  localparam logic [31:0] PXB = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  hps_address = '0;
  logic        hps_read = 1'b0;
  logic [31:0] hps_readdata;
  logic        hps_write = 1'b0;
  logic [31:0] hps_writedata = '0;
  logic        hps_waitrequest;
  logic [31:0] vga_px_address;
  logic        vga_px_write;
  logic [15:0] vga_px_writedata;
  logic        vga_px_waitrequest = 1'b0;

  always #5 clk = ~clk;

  snake_draw_engine #(
    .FIFO_DEPTH(8), .CELL_LOG2(2), .SCREEN_W(18), .SCREEN_H(10),
    .PX_BASE(PXB), .SNAKE_COLOUR(16'hFF00), .BG_COLOUR(16'h0000)
  ) dut (
    .clk(clk), .reset(reset),
    .hps_address(hps_address), .hps_read(hps_read), .hps_readdata(hps_readdata),
    .hps_write(hps_write), .hps_writedata(hps_writedata), .hps_waitrequest(hps_waitrequest),
    .vga_px_address(vga_px_address), .vga_px_write(vga_px_write),
    .vga_px_writedata(vga_px_writedata), .vga_px_waitrequest(vga_px_waitrequest)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // 0 = never stall, 1 = random stall, 2 = stall every cycle
  int stall_mode = 0;
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0:       vga_px_waitrequest = 1'b0;
      1:       vga_px_waitrequest = 1'($urandom_range(0, 1));
      default: vga_px_waitrequest = 1'b1;
    endcase
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         wr_log[$];
  int          stab_err = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!vga_px_write || vga_px_address !== prev_addr ||
                         vga_px_writedata !== prev_data))
        stab_err++;
      if (vga_px_write && !vga_px_waitrequest)
        wr_log.push_back('{vga_px_address, vga_px_writedata, cyc});
      prev_stall = vga_px_write && vga_px_waitrequest;
      prev_addr  = vga_px_address;
      prev_data  = vga_px_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hps_rd(input logic [3:0] a, output logic [31:0] d);
    hps_address = a;
    hps_read    = 1'b1;
    tick();
    hps_read    = 1'b0;
    hps_address = '0;
    d = hps_readdata;
  endtask

  task automatic hps_wr(input logic [31:0] d);
    int n = 0;
    hps_address   = 4'd0;
    hps_writedata = d;
    hps_write     = 1'b1;
    @(negedge clk);
    while (hps_waitrequest && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (hps_waitrequest) timeout("hps_write_accept");
    tick();
    hps_write = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int n = 0;
    do begin
      hps_rd(4'd0, st);
      n++;
    end while ((st[15:8] != 8'd0 || st[1]) && n < 2000);
    if (st[15:8] != 8'd0 || st[1]) timeout("wait_idle");
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          stall;
    int          n_wr;
    logic [31:0] first;
    logic [31:0] last;
    logic [15:0] colour;
    logic [31:0] status;
    logic [31:0] score;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    int base, sbase, bad, n;

    vecs[0]  = '{32'h0008_0404, 0,   0, 32'h0,         32'h0,         16'h0000, 32'h0, 32'h0};
    vecs[1]  = '{32'h0000_0000, 0, 180, 32'h0800_0000, 32'h0800_2422, 16'h0000, 32'h1, 32'h0};
    vecs[2]  = '{32'h0008_0404, 0,  16, 32'h0800_1010, 32'h0800_1C16, 16'hFF00, 32'h1, 32'h0};
    vecs[3]  = '{32'h0008_0404, 1,  16, 32'h0800_1010, 32'h0800_1C16, 16'hFF00, 32'h1, 32'h0};
    vecs[4]  = '{32'h000C_0000, 1,  16, 32'h0800_0000, 32'h0800_0C06, 16'h0000, 32'h1, 32'h0};
    vecs[5]  = '{32'h0008_0808, 0,   4, 32'h0800_2020, 32'h0800_2422, 16'hFF00, 32'h1, 32'h0};
    vecs[6]  = '{32'h000B_FFFE, 0,   0, 32'h0,         32'h0,         16'h0000, 32'h1, 32'h0};
    vecs[7]  = '{32'h0010_ABCD, 0,   0, 32'h0,         32'h0,         16'h0000, 32'h1, 32'hABCD};
    vecs[8]  = '{32'h001C_1234, 0,   0, 32'h0,         32'h0,         16'h0000, 32'h1, 32'hABCD};
    vecs[9]  = '{32'h0004_0000, 0,   0, 32'h0,         32'h0,         16'h0000, 32'h0, 32'hABCD};
    vecs[10] = '{32'h000C_0000, 0,   0, 32'h0,         32'h0,         16'h0000, 32'h0, 32'hABCD};
    vecs[11] = '{32'h0000_0000, 1, 180, 32'h0800_0000, 32'h0800_2422, 16'h0000, 32'h1, 32'hABCD};

    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_px_write", 32'(vga_px_write), 32'h0);
    check("rst_px_addr", vga_px_address, PXB);
    check("rst_px_data", 32'(vga_px_writedata), 32'h0);
    check("rst_waitreq", 32'(hps_waitrequest), 32'h0);
    check("rst_readdata", hps_readdata, 32'h0);
    hps_rd(4'd0, rd); check("rst_status", rd, 32'h0);
    hps_rd(4'd1, rd); check("rst_score", rd, 32'h0);

    for (int i = 0; i < 12; i++) begin
      base  = wr_log.size();
      sbase = stab_err;
      stall_mode = vecs[i].stall;
      hps_wr(vecs[i].cmd);
      wait_idle();
      stall_mode = 0;
      check($sformatf("v%0d_nwr", i), 32'(wr_log.size() - base), 32'(vecs[i].n_wr));
      if (vecs[i].n_wr > 0 && wr_log.size() > base) begin
        check($sformatf("v%0d_first", i), wr_log[base].addr, vecs[i].first);
        check($sformatf("v%0d_last", i), wr_log[wr_log.size()-1].addr, vecs[i].last);
        bad = 0;
        for (int k = base; k < wr_log.size(); k++)
          if (wr_log[k].data !== vecs[i].colour) bad++;
        check($sformatf("v%0d_colour_bad", i), 32'(bad), 32'h0);
      end
      check($sformatf("v%0d_stable", i), 32'(stab_err - sbase), 32'h0);
      hps_rd(4'd0, rd); check($sformatf("v%0d_status", i), rd, vecs[i].status);
      hps_rd(4'd1, rd); check($sformatf("v%0d_score", i), rd, vecs[i].score);
    end

    // Back-to-back pixels with no stall: 16 accepts on consecutive cycles
    base = wr_log.size();
    hps_wr(32'h0008_0404);
    wait_idle();
    check("tput_nwr", 32'(wr_log.size() - base), 32'd16);
    if (wr_log.size() - base == 16)
      check("tput_span", 32'(wr_log[base+15].cyc - wr_log[base].cyc), 32'd15);

    // Fill the FIFO behind a stalled engine, then push a 9th write
    base  = wr_log.size();
    sbase = stab_err;
    stall_mode = 2;
    hps_wr(32'h0008_0404);
    repeat (4) tick();
    for (int i = 0; i < 8; i++) hps_wr(32'h0008_0404);
    hps_rd(4'd0, rd); check("full_status", rd, 32'h0000_0807);
    hps_address   = 4'd5;
    hps_writedata = 32'h0008_0404;
    hps_write     = 1'b1;
    @(negedge clk);
    check("full_other_addr_wait", 32'(hps_waitrequest), 32'h0);
    tick();
    hps_address = 4'd0;
    @(negedge clk);
    check("full_wait_high", 32'(hps_waitrequest), 32'h1);
    stall_mode = 0;
    n = 0;
    while (hps_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (hps_waitrequest) timeout("full_wait_release");
    check("full_wait_len_ok", 32'(n >= 16 && n <= 20), 32'h1);
    tick();
    hps_write = 1'b0;
    hps_rd(4'd0, rd); check("push_pop_full_status", rd, 32'h0000_0807);
    wait_idle();
    check("full_total_nwr", 32'(wr_log.size() - base), 32'd160);
    check("full_stable", 32'(stab_err - sbase), 32'h0);

    // Reset in the middle of a draw with more commands queued
    stall_mode = 1;
    hps_wr(32'h0008_0404);
    hps_wr(32'h0010_5555);
    hps_wr(32'h0008_0808);
    repeat (3) tick();
    reset = 1'b1;
    stall_mode = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_px_write", 32'(vga_px_write), 32'h0);
    check("mid_rst_px_addr", vga_px_address, PXB);
    base = wr_log.size();
    hps_rd(4'd0, rd); check("mid_rst_status", rd, 32'h0);
    hps_rd(4'd1, rd); check("mid_rst_score", rd, 32'h0);
    hps_wr(32'h0008_0404);
    repeat (40) tick();
    check("post_rst_add_nwr", 32'(wr_log.size() - base), 32'h0);
    hps_rd(4'd0, rd); check("post_rst_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
